// File: rtl/rr_arb_mux_4_pkg.sv
// rr_arb_pkg: shared types and the round-robin grant function for the
// four-channel arbiter/mux.
//   N_CH      - number of arbitrated channels
//   ch_idx_t  - encoded channel index
//   rr_next() - one-hot grant for a request vector, searching from last+1
package rr_arb_pkg;

    localparam int unsigned N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    // Search order is last+1, last+2, last+3, last; the 2-bit index wraps
    // naturally, so the previous winner is considered last.
    function automatic logic [N_CH-1:0] rr_next(ch_idx_t last, logic [N_CH-1:0] req);
        logic [N_CH-1:0] g;
        logic            found;
        ch_idx_t         c;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            c = last + ch_idx_t'(k);
            if (!found && req[c]) begin
                g[c]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arb_mux_4_if.sv
// rr_arb_mux_4_if: producer-side and consumer-side handshake bundle of the
// four-channel round-robin arbiter/mux.
//   in_valid/in_ready - per-channel valid/ready (bit i = channel i)
//   d0..d3            - channel data, W bits each
//   out_valid/out_ready, out_data, out_sel - registered output stage
// Modports: slave = the arbiter, master = the surrounding environment.
interface rr_arb_mux_4_if
    import rr_arb_pkg::*;
#(
    parameter int unsigned W = 4
);

    logic [N_CH-1:0] in_valid;
    logic [N_CH-1:0] in_ready;
    logic [W-1:0]    d0;
    logic [W-1:0]    d1;
    logic [W-1:0]    d2;
    logic [W-1:0]    d3;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    ch_idx_t         out_sel;

    modport slave (
        input  in_valid,
        input  d0,
        input  d1,
        input  d2,
        input  d3,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output d0,
        output d1,
        output d2,
        output d3,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

endinterface

// File: rtl/rr_arb_mux_4_pick.sv
// rr_pick_4: purely combinational round-robin priority picker.
//   req   - request vector, bit i = channel i
//   last  - most recently served channel; search starts at last+1
//   grant - one-hot winner, all zeros when nothing requests
//   idx   - encoded winner (0 when grant is all zeros)
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         last,
    output logic [N_CH-1:0] grant,
    output ch_idx_t         idx
);

    assign grant = rr_next(last, req);

    // One-hot to binary encode of the grant.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                idx = ch_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_4.sv
// rr_arb_mux_4: four-channel round-robin arbiter feeding a one-entry
// registered 4:1 output stage; one word per cycle without backpressure.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (deassertion synchronised upstream)
//   bus   - rr_arb_mux_4_if.slave: in_valid/in_ready/d0..d3 from producers,
//           out_valid/out_ready/out_data/out_sel to the consumer.
// in_ready is the only combinational output; everything else is a flop.
module rr_arb_mux_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned W = 4
)(
    input  logic           clk,
    input  logic           rst_n,
    rr_arb_mux_4_if.slave  bus
);

    logic [N_CH-1:0] grant_c;
    ch_idx_t         idx_c;
    logic            load_c;
    logic            xfer_c;
    logic [W-1:0]    pick_data_c;

    logic            valid_q;
    logic [W-1:0]    data_q;
    ch_idx_t         sel_q;
    ch_idx_t         last_q;

    rr_pick_4 u_pick (
        .req   (bus.in_valid),
        .last  (last_q),
        .grant (grant_c),
        .idx   (idx_c)
    );

    // Output register may take a new word when empty or being drained now.
    assign load_c       = !valid_q || bus.out_ready;
    assign xfer_c       = load_c && (grant_c != '0);
    assign bus.in_ready = grant_c & {N_CH{load_c}};

    // 4:1 data select driven by the encoded winner.
    always_comb begin
        pick_data_c = bus.d0;
        case (idx_c)
            2'd0:    pick_data_c = bus.d0;
            2'd1:    pick_data_c = bus.d1;
            2'd2:    pick_data_c = bus.d2;
            default: pick_data_c = bus.d3;
        endcase
    end

    // Output stage and priority pointer; last moves only on an input transfer
    // so idle or stalled cycles do not rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= ch_idx_t'(N_CH - 1);
        end else if (xfer_c) begin
            valid_q <= 1'b1;
            data_q  <= pick_data_c;
            sel_q   <= idx_c;
            last_q  <= idx_c;
        end else if (load_c) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
module tb_rr_arb_mux_4;
    import rr_arb_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        ch_idx_t      sel;
        logic [W-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_arb_mux_4_if #(.W(W)) bus ();

    rr_arb_mux_4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] rot_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ch_idx_t sel, input logic [W-1:0] data);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
        bus.d0 = a;
        bus.d1 = b;
        bus.d2 = c;
        bus.d3 = d;
    endtask

    // Scoreboard monitor: every word the consumer takes must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got sel=%0d data=%0h want no word (t=%0t)",
                         bus.out_sel, bus.out_data, $time);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_sel !== mon_e.sel || bus.out_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL sb_word: got sel=%0d data=%0h want sel=%0d data=%0h (t=%0t)",
                             bus.out_sel, bus.out_data, mon_e.sel, mon_e.data, $time);
                end
            end
        end
    end

    initial begin
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        set_data('0, '0, '0, '0);
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_sel",   32'(bus.out_sel),   32'd0);
        step();
        rst_n = 1'b1;

        // Rotation from reset: 0,1,2,3,0,1
        set_data(4'hA, 4'hB, 4'hC, 4'hD);
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        push(2'd0, 4'hA); push(2'd1, 4'hB); push(2'd2, 4'hC);
        push(2'd3, 4'hD); push(2'd0, 4'hA); push(2'd1, 4'hB);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rot_rdy", 32'(bus.in_ready), 32'(rot_rdy[i]));
            step();
        end

        // Single requester on channel 2
        bus.in_valid = 4'b0100;
        bus.d2       = 4'h5;
        for (int i = 0; i < 4; i++) begin
            push(2'd2, 4'h5);
            @(negedge clk);
            chk("single_rdy", 32'(bus.in_ready), 32'b0100);
            step();
        end
        bus.in_valid = '0;
        step();

        // Backpressure: hold 7 for 3 cycles, then grant follows pre-stall last (=1)
        bus.d1        = 4'h7;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b0;
        push(2'd1, 4'h7);
        @(negedge clk);
        chk("bp_load_rdy", 32'(bus.in_ready), 32'b0010);
        step();
        set_data(4'hA, 4'hB, 4'hC, 4'hD);
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy",   32'(bus.in_ready),  32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data",  32'(bus.out_data),  32'h7);
            step();
        end
        bus.out_ready = 1'b1;
        push(2'd2, 4'hC);
        @(negedge clk);
        chk("bp_release_rdy", 32'(bus.in_ready), 32'b0100);
        step();
        bus.in_valid = '0;
        step();

        // Skip: last=1, in_valid=1001 -> channel 3 then channel 0
        bus.in_valid = 4'b0010;
        push(2'd1, 4'hB);
        @(negedge clk);
        chk("skip_pre_rdy", 32'(bus.in_ready), 32'b0010);
        step();
        bus.in_valid = 4'b1001;
        push(2'd3, 4'hD);
        push(2'd0, 4'hA);
        @(negedge clk);
        chk("skip_rdy_a", 32'(bus.in_ready), 32'b1000);
        step();
        @(negedge clk);
        chk("skip_rdy_b", 32'(bus.in_ready), 32'b0001);
        step();

        // Drain: valid falls one cycle after the transfer, data holds
        bus.in_valid = '0;
        step();
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_data",  32'(bus.out_data),  32'hA);
        chk("drain_sel",   32'(bus.out_sel),   32'd0);
        step();
        @(negedge clk);
        chk("drain_valid2", 32'(bus.out_valid), 32'd0);
        chk("drain_data2",  32'(bus.out_data),  32'hA);
        step();

        // Async reset while a stalled word is held; that word is dropped
        bus.in_valid  = 4'b0100;
        bus.d2        = 4'hC;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("ar_load_rdy", 32'(bus.in_ready), 32'b0100);
        step();
        bus.in_valid = '0;
        @(negedge clk);
        chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("ar_pre_data",  32'(bus.out_data),  32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_data",  32'(bus.out_data),  32'd0);
        chk("ar_sel",   32'(bus.out_sel),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_data(4'hA, 4'hB, 4'hC, 4'hD);
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        push(2'd0, 4'hA);
        @(negedge clk);
        chk("ar_post_rdy", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = '0;
        step();
        step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux_4.md
# rr_arb_mux_4

Four-channel round-robin arbiter with a registered 4:1 output stage. Sits directly upstream of the downstream consumer of a 4:1 data mux. It chooses which of four valid/ready producers is forwarded, drives the select index, and holds the selected word in a one-entry output register. Throughput is one word per cycle under no backpressure.

## Interface

- Parameters
  - `W`, default 4: data width of every channel.
- Ports
  - `clk` input, 1 bit: the single clock, rising edge.
  - `rst_n` input, 1 bit: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
  - `in_valid` input, 4 bits: bit i means channel i is offering `d<i>`.
  - `in_ready` output, 4 bits: bit i means channel i's word is accepted this cycle. At most one bit is set.
  - `d0`, `d1`, `d2`, `d3` input, W bits each: channel data.
  - `out_valid` output, 1 bit: the output register holds a word.
  - `out_ready` input, 1 bit: the consumer takes the word.
  - `out_data` output, W bits: the registered selected word.
  - `out_sel` output, 2 bits: registered index of the channel that supplied `out_data`.

## Operation

- Load enable: `load = !out_valid || out_ready`.
- Priority order starts at `(last + 1) mod 4` and wraps.
  - `last` is a 2-bit register holding the most recently transferred channel.
  - `grant` is one-hot: the first channel in priority order whose `in_valid` is 1. It is all zeros if no channel is valid.
- `in_ready = grant & {4{load}}`. Input transfer on channel i happens when `in_valid[i] && in_ready[i]`.
- On an input transfer:
  - `out_data` is loaded with `d<i>`.
  - `out_sel` is loaded with i.
  - `out_valid` is set to 1.
  - `last` is loaded with i.
- When `load` is 1 and no channel is valid: `out_valid` goes to 0, and `out_data`, `out_sel` and `last` hold.
- When `out_valid && !out_ready`:
  - `out_data`, `out_sel`, `out_valid` and `last` hold.
  - All `in_ready` bits are 0.
- A simultaneous output transfer and input transfer in the same cycle keeps `out_valid` at 1 and loads the new word. There is no bubble.
- A producer must keep `in_valid` and its data stable until it sees its `in_ready`. A channel that loses arbitration is simply not readied.
- `last` updates only on an input transfer. Idle or stalled cycles do not rotate priority.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0.
  - `last` = 3, so channel 0 has first priority after reset.
- Reset asserted mid-operation drops the held word; it is not replayed.

## Timing

- Latency: an input transfer at edge N makes `out_valid`/`out_data` visible after edge N.
- `in_ready` is combinational from `in_valid`, `out_ready`, `out_valid` and `last`. No other combinational paths exist.
- Every output except `in_ready` is a flop.
- `rst_n` falling clears all flops immediately, without waiting for a clock edge. Deassertion must be synchronous to `clk` and is provided externally.
- Fairness: with all four channels continuously valid and no backpressure, each channel receives exactly one grant in every 4 consecutive transfers.

## Structure

- Package `rr_arb_pkg`:
  - `localparam N_CH = 4`.
  - `typedef logic [1:0] ch_idx_t`.
  - Function `rr_next(ch_idx_t last, logic [3:0] req)` returning one-hot grant.
- One sub-module, `rr_pick_4`: purely combinational priority picker.
  - Inputs `req[3:0]` and `last`.
  - Outputs one-hot `grant` and encoded `idx`.
- The top level holds the load logic, the output register and `last`.
- The data select uses `idx` as a 4:1 select.

## Test plan

1. **Rotation:** `d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD`, all four `in_valid` held at 1, `out_ready` = 1, starting from reset. Required: `out_sel` sequence 0,1,2,3,0,1 and `out_data` A,B,C,D,A,B on consecutive cycles.
2. **Single requester:** only `in_valid[2]` = 1 with `d2 = 4'h5`. Required: `in_ready = 4'b0100` every cycle, and `out_sel` = 2, `out_data` = 5 every cycle after the first.
3. **Backpressure:** `out_valid` = 1 with `out_data = 4'h7`, then `out_ready` = 0 for 3 cycles. Required: `out_data` stays 7, `in_ready` = 0, `last` unchanged. On release, the next grant follows the pre-stall `last`.
4. **Skip:** `last` = 1, `in_valid = 4'b1001`. Required: channel 3 is granted first, then channel 0. Channels 1 and 2 are never readied.
5. **Drain:** one word loaded, then all `in_valid` = 0 and `out_ready` = 1. Required: `out_valid` falls to 0 one cycle after the transfer, and `out_data` holds its value.
6. **Async reset:** pulse `rst_n` low between clock edges while `out_valid` = 1. Required: `out_valid` goes to 0 before the next edge. After release with all channels valid, the first `out_sel` is 0.
